// File: rtl/cnn_pkg.sv
// Shared pixel type, default width and window tap indexing for the CNN line-buffer blocks.
package cnn_pkg;

    localparam int unsigned DATA_W_DEFAULT = 8;

    typedef logic [DATA_W_DEFAULT-1:0] pixel_t;

    // Chain entry holding window element (i,j) once the window's newest pixel has entered entry 0.
    function automatic int unsigned tap_idx(
        input int unsigned i,
        input int unsigned j,
        input int unsigned k,
        input int unsigned img_w
    );
        return (k - 1 - i) * img_w + (k - 1 - j);
    endfunction

endpackage

// File: rtl/tap_shift_reg.sv
// Enabled DATA_W x DEPTH shift register; entry 0 takes the new word and every entry is tapped.
module tap_shift_reg #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    shift_en,
    input  logic [DATA_W-1:0]       shift_in,
    output logic [DEPTH*DATA_W-1:0] taps
);

    logic [DEPTH*DATA_W-1:0] chain;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            chain <= '0;
        end else if (shift_en) begin
            chain <= {chain[(DEPTH-1)*DATA_W-1:0], shift_in};
        end
    end

    assign taps = chain;

endmodule

// File: rtl/conv_window_buffer.sv
// Raster-stream KxK window generator: line buffer chain, position counters and registered window output.
module conv_window_buffer
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned IMG_H  = 8,
    parameter int unsigned K      = 3
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic                       in_sof,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       win_valid,
    output logic [K*K*DATA_W-1:0]      win_data,
    output logic [$clog2(IMG_H)-1:0]   win_row,
    output logic [$clog2(IMG_W)-1:0]   win_col,
    output logic                       frame_done
);

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned DEPTH = (K - 1) * IMG_W + K;
    localparam int unsigned WIN_W = K * K * DATA_W;

    logic [COL_W-1:0]        col, col_next, pos_col;
    logic [ROW_W-1:0]        row, row_next, pos_row;
    logic [DEPTH*DATA_W-1:0] taps;
    logic [DEPTH*DATA_W-1:0] shifted;
    logic [DATA_W-1:0]       oldest_tap_unused;
    logic [WIN_W-1:0]        window;
    logic                    at_window;
    logic                    at_last;

    tap_shift_reg #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_chain (
        .clock    (clock),
        .reset    (reset),
        .shift_en (in_valid),
        .shift_in (in_data),
        .taps     (taps)
    );

    // The window is taken from the chain as it will look after this pixel shifts in,
    // which keeps latency at one cycle; the oldest entry is therefore never read.
    assign shifted           = {taps[(DEPTH-1)*DATA_W-1:0], in_data};
    assign oldest_tap_unused = taps[DEPTH*DATA_W-1 -: DATA_W];

    for (genvar i = 0; i < K; i++) begin : g_win_row
        for (genvar j = 0; j < K; j++) begin : g_win_col
            localparam int unsigned TAP = tap_idx(i, j, K, IMG_W);
            assign window[(i*K+j)*DATA_W +: DATA_W] = shifted[TAP*DATA_W +: DATA_W];
        end
    end

    // Position of the incoming pixel and the counter advance; in_sof forces (0,0).
    always_comb begin
        pos_col   = in_sof ? '0 : col;
        pos_row   = in_sof ? '0 : row;
        at_window = (pos_row >= ROW_W'(K - 1)) && (pos_col >= COL_W'(K - 1));
        at_last   = (pos_row == ROW_W'(IMG_H - 1)) && (pos_col == COL_W'(IMG_W - 1));
        col_next  = pos_col + COL_W'(1);
        row_next  = pos_row;
        if (pos_col == COL_W'(IMG_W - 1)) begin
            col_next = '0;
            row_next = (pos_row == ROW_W'(IMG_H - 1)) ? '0 : pos_row + ROW_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col        <= '0;
            row        <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            win_data   <= '0;
            win_row    <= '0;
            win_col    <= '0;
        end else begin
            win_valid  <= in_valid && at_window;
            frame_done <= in_valid && at_window && at_last;
            if (in_valid) begin
                col <= col_next;
                row <= row_next;
                if (at_window) begin
                    win_data <= window;
                    win_row  <= pos_row;
                    win_col  <= pos_col;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_window_buffer.sv
// Bench for conv_window_buffer: frame-array scoreboard for K=3 8x8 plus a known-answer window table.
module tb_conv_window_buffer;
    import cnn_pkg::*;

    typedef struct {
        int         r;
        int         c;
        logic [199:0] d;
        logic       fd;
    } win_t;

    typedef struct {
        int   scen;
        int   idx;
        int   r;
        int   c;
        int   base;
        logic fd;
    } kat_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset;

    logic         a_valid, a_sof;
    pixel_t       a_data;
    logic         a_wv, a_fd;
    logic [71:0]  a_wd;
    logic [2:0]   a_wr, a_wc;

    logic         b_valid, b_sof;
    pixel_t       b_data;
    logic         b_wv, b_fd;
    logic [199:0] b_wd;
    logic [2:0]   b_wr, b_wc;

    conv_window_buffer #(.DATA_W(8), .IMG_W(8), .IMG_H(8), .K(3)) dut_a (
        .clock(clock), .reset(reset), .in_valid(a_valid), .in_sof(a_sof), .in_data(a_data),
        .win_valid(a_wv), .win_data(a_wd), .win_row(a_wr), .win_col(a_wc), .frame_done(a_fd)
    );

    conv_window_buffer #(.DATA_W(8), .IMG_W(6), .IMG_H(5), .K(5)) dut_b (
        .clock(clock), .reset(reset), .in_valid(b_valid), .in_sof(b_sof), .in_data(b_data),
        .win_valid(b_wv), .win_data(b_wd), .win_row(b_wr), .win_col(b_wc), .frame_done(b_fd)
    );

    int     errors = 0;
    int     checks = 0;
    win_t   exp_q[$];
    win_t   cap_a[$];
    win_t   cap_b[$];
    int     scen_base[7];
    int     fd_seen;
    int     m_row, m_col;
    pixel_t img[8][8];
    kat_t   kat[14];

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    // Expected flattened window whose top-left pixel value is base, on a raster of width w.
    function automatic logic [199:0] pk(input int base, input int k, input int w);
        logic [199:0] v;
        v = '0;
        for (int i = 0; i < k; i++)
            for (int j = 0; j < k; j++)
                v[(i*k+j)*8 +: 8] = 8'(base + i*w + j);
        return v;
    endfunction

    task automatic model_reset();
        m_row = 0;
        m_col = 0;
        exp_q.delete();
    endtask

    // Frame-array reference for the K=3, 8x8 instance.
    task automatic model_pixel(input logic sof, input pixel_t d);
        win_t e;
        if (sof) begin
            m_row = 0;
            m_col = 0;
        end
        img[m_row][m_col] = d;
        if (m_row >= 2 && m_col >= 2) begin
            e.r  = m_row;
            e.c  = m_col;
            e.d  = '0;
            e.fd = (m_row == 7 && m_col == 7);
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    e.d[(i*3+j)*8 +: 8] = img[m_row-2+i][m_col-2+j];
            exp_q.push_back(e);
        end
        if (m_col == 7) begin
            m_col = 0;
            m_row = (m_row == 7) ? 0 : m_row + 1;
        end else begin
            m_col++;
        end
    endtask

    // One clock: drive at negedge, accept at posedge, check outputs at the following negedge.
    task automatic cycle(input logic sel_b, input logic v, input logic sof, input int d);
        win_t e;
        win_t w;
        logic acc_a, acc_b;
        acc_a   = !sel_b && v;
        acc_b   = sel_b && v;
        a_valid = acc_a;
        a_sof   = acc_a && sof;
        a_data  = pixel_t'(d);
        b_valid = acc_b;
        b_sof   = acc_b && sof;
        b_data  = pixel_t'(d);
        if (acc_a) model_pixel(sof, pixel_t'(d));
        @(posedge clock);
        @(negedge clock);
        if (a_wv) begin
            w.r  = int'(a_wr);
            w.c  = int'(a_wc);
            w.d  = 200'(a_wd);
            w.fd = a_fd;
            cap_a.push_back(w);
            if (a_fd) fd_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_window: got row %0d col %0d, want no window", a_wr, a_wc);
            end else begin
                e = exp_q.pop_front();
                chk("window", {a_fd, a_wr, a_wc, a_wd}, {e.fd, 3'(e.r), 3'(e.c), e.d[71:0]});
            end
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL missing_window: got none, want row %0d col %0d", exp_q[0].r, exp_q[0].c);
            exp_q.delete();
        end
        if (!acc_a) chk("idle_a", {a_wv, a_fd}, 2'b00);
        if (b_wv) begin
            w.r  = int'(b_wr);
            w.c  = int'(b_wc);
            w.d  = b_wd;
            w.fd = b_fd;
            cap_b.push_back(w);
        end
        if (!acc_b) chk("idle_b", {b_wv, b_fd}, 2'b00);
        a_valid = 1'b0;
        a_sof   = 1'b0;
        b_valid = 1'b0;
        b_sof   = 1'b0;
    endtask

    initial begin
        int   f0;
        int   p;
        int   cyc;
        int   n;
        win_t w;
        logic [199:0] expd;

        kat[0]  = '{1,  0, 2, 2,   0, 1'b0};
        kat[1]  = '{1, 35, 7, 7,  45, 1'b1};
        kat[2]  = '{2,  0, 2, 2,   0, 1'b0};
        kat[3]  = '{2, 35, 7, 7,  45, 1'b1};
        kat[4]  = '{3,  0, 2, 2,   0, 1'b0};
        kat[5]  = '{3, 35, 7, 7,  45, 1'b1};
        kat[6]  = '{3, 36, 2, 2,  64, 1'b0};
        kat[7]  = '{3, 71, 7, 7, 109, 1'b1};
        kat[8]  = '{4,  0, 2, 2, 100, 1'b0};
        kat[9]  = '{4, 35, 7, 7, 145, 1'b1};
        kat[10] = '{5,  0, 2, 2,   0, 1'b0};
        kat[11] = '{5, 35, 7, 7,  45, 1'b1};
        kat[12] = '{6,  0, 4, 4,   0, 1'b0};
        kat[13] = '{6,  1, 4, 5,   1, 1'b1};

        reset   = 1'b0;
        a_valid = 1'b0; a_sof = 1'b0; a_data = '0;
        b_valid = 1'b0; b_sof = 1'b0; b_data = '0;
        fd_seen = 0;
        model_reset();
        repeat (2) @(negedge clock);
        chk("reset_a", {a_wv, a_fd, a_wr, a_wc, a_wd}, '0);
        chk("reset_b", {b_wv, b_fd, b_wr, b_wc, b_wd}, '0);
        reset = 1'b1;

        // Single frame, continuous stream.
        scen_base[1] = cap_a.size(); f0 = fd_seen;
        for (int i = 0; i < 64; i++) cycle(1'b0, 1'b1, i == 0, i);
        chk("s1_windows", cap_a.size() - scen_base[1], 36);
        chk("s1_frame_done", fd_seen - f0, 1);

        // Same frame with a bubble on every third cycle.
        scen_base[2] = cap_a.size(); f0 = fd_seen;
        p = 0; cyc = 0;
        while (p < 64) begin
            if (cyc % 3 == 2) cycle(1'b0, 1'b0, 1'b0, 0);
            else begin
                cycle(1'b0, 1'b1, p == 0, p);
                p++;
            end
            cyc++;
        end
        chk("s2_windows", cap_a.size() - scen_base[2], 36);
        chk("s2_frame_done", fd_seen - f0, 1);

        // Two frames back to back, second one entered by counter wrap only.
        scen_base[3] = cap_a.size(); f0 = fd_seen;
        for (int i = 0; i < 128; i++) cycle(1'b0, 1'b1, i == 0, i);
        chk("s3_windows", cap_a.size() - scen_base[3], 72);
        chk("s3_frame_done", fd_seen - f0, 2);

        // Frame aborted by in_sof at pixel 30, then a full new frame.
        f0 = fd_seen;
        for (int i = 0; i < 30; i++) cycle(1'b0, 1'b1, i == 0, i);
        scen_base[4] = cap_a.size();
        for (int i = 0; i < 64; i++) cycle(1'b0, 1'b1, i == 0, 100 + i);
        chk("s4_windows", cap_a.size() - scen_base[4], 36);
        chk("s4_frame_done", fd_seen - f0, 1);

        // Asynchronous reset mid-row, then restart without in_sof.
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, i == 0, i);
        a_valid = 1'b1;
        a_data  = 8'd20;
        #2 reset = 1'b0;
        #1 chk("async_reset", {a_wv, a_fd, a_wr, a_wc, a_wd}, '0);
        a_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        scen_base[5] = cap_a.size(); f0 = fd_seen;
        for (int i = 0; i < 64; i++) cycle(1'b0, 1'b1, 1'b0, i);
        chk("s5_windows", cap_a.size() - scen_base[5], 36);
        chk("s5_frame_done", fd_seen - f0, 1);

        // K=5 on a 6x5 image.
        scen_base[6] = cap_b.size();
        for (int i = 0; i < 30; i++) cycle(1'b1, 1'b1, i == 0, i);
        chk("s6_windows", cap_b.size() - scen_base[6], 2);

        for (int t = 0; t < 14; t++) begin
            n = scen_base[kat[t].scen] + kat[t].idx;
            if (kat[t].scen == 6) begin
                expd = pk(kat[t].base, 5, 6);
                if (n < cap_b.size()) w = cap_b[n];
                else w.r = -1;
            end else begin
                expd = pk(kat[t].base, 3, 8);
                if (n < cap_a.size()) w = cap_a[n];
                else w.r = -1;
            end
            if (w.r < 0) begin
                checks++;
                errors++;
                $display("FAIL kat%0d: got no window at index %0d, want row %0d col %0d", t, n, kat[t].r, kat[t].c);
            end else begin
                chk($sformatf("kat%0d", t), {w.fd, 8'(w.r), 8'(w.c), w.d},
                    {kat[t].fd, 8'(kat[t].r), 8'(kat[t].c), expd});
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_window_buffer.md
Name: conv_window_buffer

Overview:
- Parametrised successor to the single-tap 8-bit pixel shift register.
- Accepts a raster-order pixel stream with a valid qualifier.
- Buffers (K-1) full image rows plus K pixels in a tapped shift chain.
- Emits a complete KxK convolution window, flattened, for every valid output position; feeds the MAC array of the conv layer.

Parameters:
- DATA_W, 8: pixel width in bits.
- IMG_W, 8: pixels per image row; must be >= K.
- IMG_H, 8: rows per frame; must be >= K.
- K, 3: kernel size (window is KxK); must be >= 2.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data and in_sof valid this cycle.
- in_sof  in  1  start of frame; qualified by in_valid; marks pixel (0,0).
- in_data  in  DATA_W  pixel value.
- win_valid  out  1  win_data holds a complete window this cycle.
- win_data  out  K*K*DATA_W  flattened window.
- win_row  out  $clog2(IMG_H)  image row of the window's bottom-right pixel.
- win_col  out  $clog2(IMG_W)  image column of the window's bottom-right pixel.
- frame_done  out  1  one-cycle pulse with the last window of a frame.

Behaviour:
- Reset (reset=0, asynchronous): shift chain, col/row counters, win_valid, win_data, win_row, win_col and frame_done all clear to 0. The first accepted pixel after reset is (0,0) whether or not in_sof is asserted.
- Acceptance: a pixel is accepted only on a clock edge where in_valid=1. There is no backpressure. When in_valid=0, the chain and counters hold, and win_valid and frame_done are 0 on the next cycle.
- Shift chain: (K-1)*IMG_W+K entries. An accepted pixel enters entry 0 and all entries shift by one.
- Counters: col increments per accepted pixel. col wraps IMG_W-1 -> 0 and increments row. row wraps IMG_H-1 -> 0, which starts the next frame.
- in_sof: an accepted pixel with in_sof=1 is forced to (0,0) regardless of the counters. Its window logic then evaluates as (0,0), so no window is produced. Chain contents are not flushed; stale data is never exposed, because no window is produced until row>=K-1 again. in_sof on any pixel other than (0,0) aborts the current frame with no frame_done.
- Window emission: an accepted pixel at (r,c) with r>=K-1 and c>=K-1 produces, one cycle later:
  - win_valid=1
  - win_row=r, win_col=c
  - win_data = pixels (r-K+1..r, c-K+1..c)
- No windows straddle a row boundary. Latency is exactly 1 cycle, with all outputs registered.
- Packing: win_data[(i*K+j)*DATA_W +: DATA_W] = pixel(r-K+1+i, c-K+1+j). i=0 is the top row and j=0 the left column. Entry index for (i,j) = (K-1-i)*IMG_W + (K-1-j).
- frame_done=1 together with the window for (IMG_H-1, IMG_W-1); otherwise 0.
- Windows per frame: (IMG_H-K+1)*(IMG_W-K+1).
- Gaps in in_valid do not change window contents or order.
- Back-to-back frames: the pixel after (IMG_H-1, IMG_W-1) is (0,0) of the next frame with no bubble. The first K-1 rows of the new frame emit nothing.
- Reset mid-frame: outputs clear immediately. The next accepted pixel is (0,0).

Decomposition:
- Package cnn_pkg holds:
  - the default DATA_W constant;
  - the tap-index function tap_idx(i,j,K,IMG_W);
  - a typedef for the pixel type.
- Sub-module tap_shift_reg: a generic DATA_W x DEPTH enabled shift register with a full parallel tap bus, async active-low reset. It is instantiated once with DEPTH=(K-1)*IMG_W+K.
- conv_window_buffer holds the counters, the window-select mux and the output registers.

Test Plan (DATA_W=8, IMG_W=IMG_H=8, K=3 unless noted):
- Reset, then in_sof on pixel 0 and continuous in_valid with in_data=0..63 -> 36 windows, in order.
  - First window one cycle after pixel 18: win_row=2, win_col=2, flattened bytes {0,1,2,8,9,10,16,17,18}.
  - Last window: {45,46,47,53,54,55,61,62,63}, win_row=7, win_col=7, frame_done=1.
- Same stream with in_valid deasserted on every third cycle -> identical 36 windows and coordinates. win_valid is 0 in the cycle after each gap.
- Two frames back-to-back, second frame data=64..127 -> 72 windows total and two frame_done pulses. No window has win_row<2 in either frame. The second frame's first window is {64,65,66,72,73,74,80,81,82}.
- in_sof asserted at pixel 30 of frame 1, then a full 64-pixel frame -> no frame_done for the aborted frame. Exactly 36 windows follow, all drawn from new-frame data only.
- Reset asserted asynchronously mid-row at pixel 20 -> win_valid, frame_done and win_data are 0 immediately. Restarting with 0..63 reproduces scenario 1 exactly.
- K=5, IMG_W=6, IMG_H=5, data=0..29 -> 2 windows.
  - (4,4) = {0..4, 6..10, 12..16, 18..22, 24..28}.
  - (4,5) = the same set +1, with frame_done on the second window.
